step_seg_display: RTL and testbench

Consumes `step_number` and `game_status` produced by the game control top level and drives a 4-digit multiplexed seven-segment display.
- Digits 1..0 show the step count in decimal (00–63).
- Digit 3 shows a letter for the game state.
- Digit 2 is blank.
- In the WINNED state the whole display blinks.

It sits on the divided clock domain, directly downstream of the game FSM outputs.

---
 rtl/step_seg_display.sv | 175 +++++++++++++++++
 tb/tb_step_seg_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/step_seg_display.sv
// rtl/step_seg_display.sv - 4-digit multiplexed seven-segment display of step count and game state (optional macro: LEADING_ZERO_BLANK_EN)
module step_seg_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] step_number,
  input  logic [1:0] game_status,
  output logic [7:0] seg_out,
  output logic [3:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] SCAN_ONE   = PW'(1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  typedef enum logic {ON = 1'b0, OFF = 1'b1} blink_t;

  logic [5:0]    step_q;
  logic [1:0]    status_q;
  logic [5:0]    tens;
  logic [5:0]    units;
  logic [5:0]    tens_n;
  logic [5:0]    units_n;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_n;
  blink_t        blink_state;
  blink_t        blink_state_n;
  logic          blink_off;
  logic [3:0]    an_n;
  logic [7:0]    seg_n;

  function automatic logic [7:0] digit_pattern(input logic [5:0] d);
    case (d)
      6'd0:    digit_pattern = 8'h3F;
      6'd1:    digit_pattern = 8'h06;
      6'd2:    digit_pattern = 8'h5B;
      6'd3:    digit_pattern = 8'h4F;
      6'd4:    digit_pattern = 8'h66;
      6'd5:    digit_pattern = 8'h6D;
      6'd6:    digit_pattern = 8'h7D;
      6'd7:    digit_pattern = 8'h07;
      6'd8:    digit_pattern = 8'h7F;
      6'd9:    digit_pattern = 8'h6F;
      default: digit_pattern = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] status_letter(input logic [1:0] s);
    case (s)
      2'b00:   status_letter = 8'h39;
      2'b01:   status_letter = 8'h73;
      2'b10:   status_letter = 8'h30;
      default: status_letter = 8'h76;
    endcase
  endfunction

  // Sample the game FSM outputs once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= 6'd0;
      status_q <= 2'b00;
    end else begin
      step_q   <= step_number;
      status_q <= game_status;
    end
  end

  // Decimal split of the sampled step; both digits come from the same sample
  always_comb begin
    tens_n  = step_q / 6'd10;
    units_n = step_q % 6'd10;
  end

  // Register tens and units together so they never mix samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 6'd0;
      units <= 6'd0;
    end else begin
      tens  <= tens_n;
      units <= units_n;
    end
  end

  // Scan prescaler and digit index; index advances on the prescaler terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == SCAN_LAST) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + SCAN_ONE;
    end
  end

  // Blink FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_state <= ON;
      blink_cnt   <= '0;
    end else begin
      blink_state <= blink_state_n;
      blink_cnt   <= blink_cnt_n;
    end
  end

  // Blink FSM next state: held ON outside WINNED, toggles every BLINK_DIV cycles inside
  always_comb begin
    blink_state_n = blink_state;
    blink_cnt_n   = blink_cnt;
    if (status_q != 2'b11) begin
      blink_state_n = ON;
      blink_cnt_n   = '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n   = '0;
      blink_state_n = (blink_state == ON) ? OFF : ON;
    end else begin
      blink_cnt_n   = blink_cnt + BLINK_ONE;
    end
  end

  // Gating also looks at the live status so leaving WINNED lights the display without waiting for the FSM
  assign blink_off = (blink_state == OFF) && (status_q == 2'b11);

  // Select the enable and pattern for the current digit
  always_comb begin
    an_n  = 4'b0000;
    seg_n = 8'h00;
    if (!blink_off) begin
      case (idx)
        2'd0: begin
          an_n  = 4'b0001;
          seg_n = digit_pattern(units);
        end
        2'd1: begin
          an_n  = 4'b0010;
`ifdef LEADING_ZERO_BLANK_EN
          seg_n = (tens == 6'd0) ? 8'h00 : digit_pattern(tens);
`else
          seg_n = digit_pattern(tens);
`endif
        end
        2'd2: begin
          an_n  = 4'b0100;
          seg_n = 8'h00;
        end
        default: begin
          an_n  = 4'b1000;
          seg_n = status_letter(status_q);
        end
      endcase
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an      <= 4'b0000;
      seg_out <= 8'h00;
    end else begin
      an      <= an_n;
      seg_out <= seg_n;
    end
  end

endmodule

// File: tb/tb_step_seg_display.sv
// tb/tb_step_seg_display.sv - randomized self-checking bench for step_seg_display against a behavioural model
module tb_step_seg_display;

  localparam int SD = 4;
  localparam int BD = 16;
  localparam int HN = 8192;

  logic       clk;
  logic       rst;
  logic [5:0] step_number;
  logic [1:0] game_status;
  logic [7:0] seg_out;
  logic [3:0] an;

  int n_tests;
  int n_fail;
  int k;

  logic [5:0] hs  [0:HN-1];
  logic [1:0] hst [0:HN-1];
  int         rl  [0:HN-1];

  logic [7:0] pat    [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [7:0] letter [0:3] = '{8'h39, 8'h73, 8'h30, 8'h76};

  step_seg_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk),
    .rst(rst),
    .step_number(step_number),
    .game_status(game_status),
    .seg_out(seg_out),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
    end
  endtask

  function automatic int g_step(input int j);
    return (j <= 0) ? 0 : int'(hs[j]);
  endfunction

  function automatic int g_stat(input int j);
    return (j <= 0) ? 0 : int'(hst[j]);
  endfunction

  function automatic int g_run(input int j);
    return (j <= 0) ? 0 : rl[j];
  endfunction

  // Expected outputs after the k-th rising edge since reset release
  task automatic model(input int kk, output logic [3:0] ean, output logic [7:0] eseg);
    int  d;
    int  s;
    bit  off;
    d   = ((kk - 1) / SD) % 4;
    s   = g_step(kk - 2);
    off = (g_stat(kk - 1) == 3) && (((g_run(kk - 1) / BD) % 2) == 1);
    ean  = 4'b0000;
    eseg = 8'h00;
    if (!off) begin
      ean = 4'(1 << d);
      case (d)
        0: eseg = pat[s % 10];
        1: begin
`ifdef LEADING_ZERO_BLANK_EN
          eseg = (s / 10 == 0) ? 8'h00 : pat[s / 10];
`else
          eseg = pat[s / 10];
`endif
        end
        2: eseg = 8'h00;
        default: eseg = letter[g_stat(kk - 1)];
      endcase
    end
  endtask

  task automatic reset_model();
    k = 0;
    hs[0]  = 6'd0;
    hst[0] = 2'b00;
    rl[0]  = 0;
  endtask

  task automatic tick();
    logic [3:0] ean;
    logic [7:0] eseg;
    @(posedge clk);
    if (k < HN - 1) k++;
    hs[k]  = step_number;
    hst[k] = game_status;
    rl[k]  = (k > 1 && hst[k-1] == 2'b11) ? rl[k-1] + 1 : 0;
    @(negedge clk);
    model(k, ean, eseg);
    check_eq("an", 32'(an), 32'(ean));
    check_eq("seg", 32'(seg_out), 32'(eseg));
    check_eq("onehot", 32'($countones(an) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input int s, input int st);
    step_number = 6'(s);
    game_status = 2'(st);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(0, 0);
    reset_model();
    repeat (2) @(negedge clk);
    check_eq("rst_an", 32'(an), 32'd0);
    check_eq("rst_seg", 32'(seg_out), 32'd0);
    rst = 1'b0;

    drive(37, 1);  run(40);
    drive(5, 0);   run(20);
    drive(63, 2);  run(20);
    drive(0, 2);   run(10);
    drive(12, 1);  run(8);
    drive(12, 3);  run(24);
    drive(12, 1);  run(10);
    drive(12, 3);  run(70);
    drive(9, 1);   run(7);
    drive(10, 1);  run(20);

    for (int seg = 0; seg < 50; seg++) begin
      int r;
      int len;
      r   = int'($urandom_range(0, 5));
      len = int'($urandom_range(1, 60));
      game_status = (r >= 3) ? 2'b11 : 2'(r);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 5) == 0) step_number = 6'($urandom_range(0, 63));
        tick();
      end
    end

    drive(21, 1);
    for (int i = 0; i < 40 && an != 4'b0100; i++) tick();
    check_eq("rst_trigger", 32'(an), 32'b0100);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_an", 32'(an), 32'd0);
    check_eq("async_rst_seg", 32'(seg_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
